status_display: RTL and testbench
=================================

// Module: status_display
// PURPOSE
//  Consumes the CPU's retirement stream: commit PC and the 8-bit exception vector.
//  Drives the eight 7-segment digits on the board.
//  RUN: shows a rate-limited snapshot of commit PC[31:0] in hex.
//  On the first ECALL/EBREAK (halt) or anomaly it freezes and shows the trap code.
//  Trap code sits beside a three-bar glyph and the trapping PC; anomalies blink.
// PARAMETERS
//  UPDATE_DIV  12_500_000  cycles between PC snapshot refreshes (>=1)
//  BLINK_DIV   25_000_000  cycles per blink half-period in FAULT (>=1)
//  ACTIVE_LOW  1           1: segment lit = 0; 0: segment lit = 1
// PORTS
//  clk_i          in   1   PLL clock
//  rst_i          in   1   synchronous, active-high reset
//  commit_valid_i in   1   commit_pc_i holds a retired instruction this cycle
//  commit_pc_i    in   32  retired PC (low 32 bits)
//  exception_i    in   8   [2:0] anomaly (fetch/decode/other), [3] ECALL, [4] EBREAK, [7:5] ignored
//  seg_o          out  56  digit k = seg_o[7k+6:7k], bit order {g,f,e,d,c,b,a}; digit 7 leftmost
//  trap_o         out  1   1 while in TRAPPED or FAULT
//  trap_code_o    out  8   latched exception_i at trap entry
// BEHAVIOUR
//  Reset:
//   - state=RUN; counters, pc_latest, disp_pc, trap_pc, trap_code_o = 0; trap_o = 0.
//   - seg_o shows "00000000" on the cycle after reset (all digits 7'b1000000 when ACTIVE_LOW).
//   - rst_i asserted in any state, including mid-trap or mid-blink, returns to this condition next edge.
//  pc_latest <= commit_pc_i on every cycle with commit_valid_i.
//  Update counter runs 0..UPDATE_DIV-1 and wraps, in RUN only.
//   - On the wrap cycle, disp_pc <= commit_pc_i if commit_valid_i that cycle, else pc_latest.
//   - UPDATE_DIV=1: disp_pc follows every commit.
//  FSM (priority FAULT > TRAPPED; evaluated every cycle, regardless of commit_valid_i):
//   - RUN -> FAULT when exception_i[2:0]!=0.
//   - RUN -> TRAPPED when exception_i[3]|exception_i[4] and no anomaly.
//   - TRAPPED -> FAULT on any anomaly; trap_code_o, trap_pc overwritten.
//   - Further ECALL/EBREAK in TRAPPED are ignored.
//   - FAULT is absorbing until reset.
//   - Entry: trap_code_o <= exception_i; trap_pc <= commit_pc_i if commit_valid_i, else pc_latest.
//     trap_o <= 1 on the same edge.
//   - Exception on an update-wrap cycle: trap entry wins; disp_pc is not updated.
//  Display map:
//   - RUN: digits 7..0 = hex nibbles of disp_pc[31:0].
//   - TRAPPED/FAULT:
//     - d7..d6 = hex of trap_code_o.
//     - d5..d4 = three-bar glyph (segs a,d,g lit).
//     - d3..d0 = hex of trap_pc[15:0].
//  Blink, FAULT only:
//   - Blink counter starts at 0 on FAULT entry; the phase toggles every BLINK_DIV cycles.
//   - First phase visible; off phase = all segments dark.
//   - TRAPPED is steady.
//  seg_o is registered: the display reflects state/disp_pc exactly 1 cycle after they change.
//  Glyphs (active-low):
//   - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
//   - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
//   - bars=0110110, dark=1111111
//   - ACTIVE_LOW=0 inverts all.
// TESTING
//  1. Reset, hold 3 cycles -> seg_o all digits 1000000, trap_o=0, trap_code_o=0.
//  2. UPDATE_DIV=4: commit 0x80000000, then 0x80000004 on count=3 cycle -> d1..d0 show "04" next cycle; no change mid-period.
//  3. exception_i=8'h10 with commit_pc_i=0x8000ABCD valid -> trap_o=1, trap_code_o=0x10.
//     seg_o = "10",bars,bars,"AbCd", steady for 100 cycles.
//  4. TRAPPED (code 0x08), then exception_i=8'h0C -> FAULT, trap_code_o=0x0C.
//     BLINK_DIV=3: 3 cycles visible, 3 dark, repeating.
//  5. exception_i=8'h02 on the same cycle as an update wrap -> FAULT; disp_pc unchanged; trap_pc = that commit PC.
//  6. rst_i pulsed for 1 cycle while FAULT is dark -> next cycle trap_o=0, all digits 1000000, state RUN.

Source files
------------

// File: rtl/status_display.sv
// Retirement-stream status display: shows a throttled commit-PC snapshot while running,
// then freezes on the first halt or anomaly and shows the trap code, a bar glyph and the trapping PC.
module status_display #(
   parameter int unsigned UPDATE_DIV = 12_500_000,
   parameter int unsigned BLINK_DIV  = 25_000_000,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        commit_valid_i,
   input  logic [31:0] commit_pc_i,
   input  logic [7:0]  exception_i,
   output logic [55:0] seg_o,
   output logic        trap_o,
   output logic [7:0]  trap_code_o
);

   typedef enum logic [1:0] {
      RUN,
      TRAPPED,
      FAULT
   } state_t;

   localparam logic [31:0] UPD_LAST   = 32'(UPDATE_DIV - 1);
   localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);
   localparam logic [6:0]  GLYPH_BARS = 7'b0110110;
   localparam logic [6:0]  GLYPH_DARK = 7'b1111111;
   localparam logic [55:0] SEG_ZEROS  = {8{7'b1000000}};
   localparam logic [55:0] SEG_RESET  = ACTIVE_LOW ? SEG_ZEROS : ~SEG_ZEROS;

   state_t      state;
   state_t      state_next;
   logic [31:0] upd_cnt;
   logic [31:0] blink_cnt;
   logic        blink_off;
   logic [31:0] pc_latest;
   logic [31:0] disp_pc;
   logic [15:0] trap_pc;
   logic [31:0] entry_pc;
   logic        anomaly;
   logic        halt;
   logic        wrap;
   logic        entry;
   logic [55:0] seg_next;

   // Glyphs are stored active-low; polarity is applied once at the output.
   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      case (nib)
         4'h0: hex_glyph = 7'b1000000;
         4'h1: hex_glyph = 7'b1111001;
         4'h2: hex_glyph = 7'b0100100;
         4'h3: hex_glyph = 7'b0110000;
         4'h4: hex_glyph = 7'b0011001;
         4'h5: hex_glyph = 7'b0010010;
         4'h6: hex_glyph = 7'b0000010;
         4'h7: hex_glyph = 7'b1111000;
         4'h8: hex_glyph = 7'b0000000;
         4'h9: hex_glyph = 7'b0010000;
         4'hA: hex_glyph = 7'b0001000;
         4'hB: hex_glyph = 7'b0000011;
         4'hC: hex_glyph = 7'b1000110;
         4'hD: hex_glyph = 7'b0100001;
         4'hE: hex_glyph = 7'b0000110;
         default: hex_glyph = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_next = state;
      anomaly    = |exception_i[2:0];
      halt       = exception_i[3] | exception_i[4];
      case (state)
         RUN: begin
            if (anomaly)   state_next = FAULT;
            else if (halt) state_next = TRAPPED;
         end
         TRAPPED: begin
            if (anomaly) state_next = FAULT;
         end
         default: ;
      endcase
      entry    = (state_next != state);
      wrap     = (state == RUN) && (upd_cnt == UPD_LAST);
      entry_pc = commit_valid_i ? commit_pc_i : pc_latest;
   end

   always_comb begin
      seg_next = '0;
      if (state == RUN) begin
         for (int k = 0; k < 8; k++) begin
            seg_next[7*k +: 7] = hex_glyph(disp_pc[4*k +: 4]);
         end
      end else begin
         seg_next = {hex_glyph(trap_code_o[7:4]), hex_glyph(trap_code_o[3:0]),
                     GLYPH_BARS, GLYPH_BARS,
                     hex_glyph(trap_pc[15:12]), hex_glyph(trap_pc[11:8]),
                     hex_glyph(trap_pc[7:4]),   hex_glyph(trap_pc[3:0])};
         if ((state == FAULT) && blink_off) seg_next = {8{GLYPH_DARK}};
      end
      if (!ACTIVE_LOW) seg_next = ~seg_next;
   end

   assign trap_o = (state != RUN);

   // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= RUN;
         upd_cnt     <= '0;
         blink_cnt   <= '0;
         blink_off   <= 1'b0;
         pc_latest   <= '0;
         disp_pc     <= '0;
         trap_pc     <= '0;
         trap_code_o <= '0;
         seg_o       <= SEG_RESET;
      end else begin
         state <= state_next;
         seg_o <= seg_next;

         if (commit_valid_i) pc_latest <= commit_pc_i;

         if (state == RUN) upd_cnt <= wrap ? '0 : upd_cnt + 32'd1;

         // A trap taken on a refresh edge leaves the snapshot untouched.
         if (wrap && !entry) disp_pc <= entry_pc;

         if (entry) begin
            trap_code_o <= exception_i;
            trap_pc     <= entry_pc[15:0];
         end

         if (entry && (state_next == FAULT)) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
         end else if (state == FAULT) begin
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt <= '0;
               blink_off <= ~blink_off;
            end else begin
               blink_cnt <= blink_cnt + 32'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_status_display.sv
// Directed bench for status_display: stimulus pushes per-cycle expectations into a queue,
// a negedge monitor pops and compares them against the outputs.
module tb_status_display;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        commit_valid = 1'b0;
   logic [31:0] commit_pc = '0;
   logic [7:0]  exception = '0;
   logic [55:0] seg;
   logic        trap;
   logic [7:0]  trap_code;

   int unsigned cyc = 0;
   int unsigned tests = 0;
   int unsigned fails = 0;

   typedef struct {
      int unsigned cyc;
      logic [55:0] seg;
      logic        trap;
      logic [7:0]  code;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   localparam logic [6:0]  BARS = 7'b0110110;
   localparam logic [55:0] DARK = {56{1'b1}};

   status_display #(
      .UPDATE_DIV(4),
      .BLINK_DIV (3),
      .ACTIVE_LOW(1'b1)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .commit_valid_i(commit_valid),
      .commit_pc_i   (commit_pc),
      .exception_i   (exception),
      .seg_o         (seg),
      .trap_o        (trap),
      .trap_code_o   (trap_code)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [6:0] g(input logic [3:0] n);
      case (n)
         4'h0: g = 7'b1000000; 4'h1: g = 7'b1111001; 4'h2: g = 7'b0100100; 4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001; 4'h5: g = 7'b0010010; 4'h6: g = 7'b0000010; 4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000; 4'h9: g = 7'b0010000; 4'hA: g = 7'b0001000; 4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110; 4'hD: g = 7'b0100001; 4'hE: g = 7'b0000110; default: g = 7'b0001110;
      endcase
   endfunction

   function automatic logic [55:0] run_seg(input logic [31:0] pc);
      logic [55:0] s;
      s = '0;
      for (int k = 0; k < 8; k++) s[7*k +: 7] = g(pc[4*k +: 4]);
      return s;
   endfunction

   function automatic logic [55:0] trap_seg(input logic [7:0] code, input logic [15:0] pc);
      return {g(code[7:4]), g(code[3:0]), BARS, BARS, g(pc[15:12]), g(pc[11:8]), g(pc[7:4]), g(pc[3:0])};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, req);
      end
   endtask

   // Queue the outputs expected right after the next rising edge, then take that edge.
   task automatic tick(input logic [55:0] s, input logic t, input logic [7:0] c, input string n);
      exp_t e;
      e.cyc  = cyc + 1;
      e.seg  = s;
      e.trap = t;
      e.code = c;
      e.name = n;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         tests++;
         fails++;
         $display("FAIL stale_%s: expectation for cyc %0d not checked, now cyc %0d", exp_q[0].name, exp_q[0].cyc, cyc);
         void'(exp_q.pop_front());
      end
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         check({e.name, "_seg"},  64'(seg),       64'(e.seg));
         check({e.name, "_trap"}, 64'(trap),      64'(e.trap));
         check({e.name, "_code"}, 64'(trap_code), 64'(e.code));
      end
   end

   initial begin
      logic [55:0] zeros;
      zeros = run_seg(32'h0);

      // Reset held three cycles.
      rst = 1'b1;
      for (int i = 0; i < 3; i++) tick(zeros, 1'b0, 8'h00, "reset");
      rst = 1'b0;

      // Snapshot refresh every 4 cycles; commit on the wrap cycle is taken directly.
      commit_valid = 1'b1; commit_pc = 32'h8000_0000;
      tick(zeros, 1'b0, 8'h00, "run_mid");
      commit_valid = 1'b0;
      tick(zeros, 1'b0, 8'h00, "run_mid");
      tick(zeros, 1'b0, 8'h00, "run_mid");
      commit_valid = 1'b1; commit_pc = 32'h8000_0004;
      tick(zeros, 1'b0, 8'h00, "run_wrap");
      commit_valid = 1'b0;
      tick(run_seg(32'h8000_0004), 1'b0, 8'h00, "run_show04");
      commit_valid = 1'b1; commit_pc = 32'h1234_5678;
      tick(run_seg(32'h8000_0004), 1'b0, 8'h00, "run_hold");
      commit_valid = 1'b0;
      tick(run_seg(32'h8000_0004), 1'b0, 8'h00, "run_hold");
      tick(run_seg(32'h8000_0004), 1'b0, 8'h00, "run_hold");

      // EBREAK with a valid commit; the wrap on the previous edge used pc_latest.
      exception = 8'h10; commit_valid = 1'b1; commit_pc = 32'h8000_ABCD;
      tick(run_seg(32'h1234_5678), 1'b1, 8'h10, "trap_entry");
      for (int i = 0; i < 100; i++) begin
         if (i == 50) begin
            exception = 8'h08; commit_valid = 1'b1; commit_pc = 32'h0000_1111;
         end else begin
            exception = 8'h00; commit_valid = 1'b0;
         end
         tick(trap_seg(8'h10, 16'hABCD), 1'b1, 8'h10, "trap_steady");
      end
      exception = 8'h00; commit_valid = 1'b0;

      // Reset out of TRAPPED, then ECALL without a commit, then anomaly -> FAULT with blink.
      rst = 1'b1;
      tick(zeros, 1'b0, 8'h00, "reset_from_trap");
      rst = 1'b0;
      exception = 8'h08;
      tick(zeros, 1'b1, 8'h08, "ecall_entry");
      exception = 8'h00;
      tick(trap_seg(8'h08, 16'h0000), 1'b1, 8'h08, "ecall_show");
      exception = 8'h0C; commit_valid = 1'b1; commit_pc = 32'h0000_BEEF;
      tick(trap_seg(8'h08, 16'h0000), 1'b1, 8'h0C, "fault_entry");
      commit_valid = 1'b0;
      for (int k = 0; k < 12; k++) begin
         exception = (k == 4) ? 8'h1F : 8'h00;
         tick(((k / 3) % 2 == 0) ? trap_seg(8'h0C, 16'hBEEF) : DARK, 1'b1, 8'h0C, "fault_blink");
      end
      exception = 8'h00;

      // Anomaly on an update-wrap edge: trap wins, snapshot stays at reset value.
      rst = 1'b1;
      tick(zeros, 1'b0, 8'h00, "reset_from_fault");
      rst = 1'b0;
      commit_valid = 1'b1; commit_pc = 32'hCAFE_0000;
      tick(zeros, 1'b0, 8'h00, "wrap_pre");
      commit_valid = 1'b0;
      tick(zeros, 1'b0, 8'h00, "wrap_pre");
      tick(zeros, 1'b0, 8'h00, "wrap_pre");
      exception = 8'h02; commit_valid = 1'b1; commit_pc = 32'hCAFE_1234;
      tick(zeros, 1'b1, 8'h02, "wrap_fault");
      check("disp_pc_hold", 64'(dut.disp_pc), 64'h0);
      exception = 8'h00; commit_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick((k < 3) ? trap_seg(8'h02, 16'h1234) : DARK, 1'b1, 8'h02, "wrap_blink");
      end

      // One-cycle reset pulse while the FAULT display is dark.
      rst = 1'b1;
      tick(zeros, 1'b0, 8'h00, "reset_dark");
      rst = 1'b0;
      for (int i = 0; i < 3; i++) tick(zeros, 1'b0, 8'h00, "run_after_reset");

      @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, expected finish before 200000");
      $fatal(1);
   end

endmodule
